// File: rtl/hazard_detection_id.sv
// ID-stage hazard detection: load-use / no-forward RAW bubbles, memory-wait freeze,
// branch flush, and saturating stall/bubble performance counters.
module hazard_detection_id #(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] src1_ID,
  input  logic [REG_ADDR_W-1:0] src2_ID,
  input  logic                  src1_vld_ID,
  input  logic                  src2_vld_ID,
  input  logic [REG_ADDR_W-1:0] dest_EXE,
  input  logic                  WB_EN_EXE,
  input  logic                  MEM_R_EN_EXE,
  input  logic [REG_ADDR_W-1:0] dest_MEM,
  input  logic                  WB_EN_MEM,
  input  logic                  forward_en,
  input  logic                  branch_taken_EXE,
  input  logic                  mem_req_MEM,
  input  logic                  mem_ready,
  output logic                  freeze_front,
  output logic                  bubble_EXE,
  output logic                  freeze_all,
  output logic                  flush_IF_ID,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic hit_exe, hit_mem, load_use, raw_nofwd, data_stall, timeout_now;

  always_comb begin
    hit_exe    = (src1_vld_ID && (src1_ID == dest_EXE)) || (src2_vld_ID && (src2_ID == dest_EXE));
    hit_mem    = (src1_vld_ID && (src1_ID == dest_MEM)) || (src2_vld_ID && (src2_ID == dest_MEM));
    load_use   = WB_EN_EXE && MEM_R_EN_EXE && hit_exe;
    raw_nofwd  = !forward_en && ((WB_EN_EXE && hit_exe) || (WB_EN_MEM && hit_mem));
    data_stall = load_use || raw_nofwd;
    timeout_now = (state_q == StMemWait) && !mem_ready && (wait_cnt_q == WaitLast);
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req_MEM && !mem_ready) begin
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          state_d    = StIdle;
          wait_cnt_d = '0;
        end else if (timeout_now) begin
          // Abort: release the pipeline and flag the lost access.
          state_d       = StIdle;
          wait_cnt_d    = '0;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rst) begin
      state_d       = StIdle;
      wait_cnt_d    = '0;
      mem_timeout_d = 1'b0;
    end
  end

  always_comb begin
    freeze_all   = 1'b0;
    flush_IF_ID  = 1'b0;
    bubble_EXE   = 1'b0;
    freeze_front = 1'b0;
    if (!rst) begin
      freeze_all = ((state_q == StIdle) && mem_req_MEM && !mem_ready) ||
                   ((state_q == StMemWait) && !mem_ready && !timeout_now);
      if (!freeze_all) begin
        if (branch_taken_EXE) begin
          flush_IF_ID = 1'b1;
          bubble_EXE  = 1'b1;
        end else if (data_stall) begin
          freeze_front = 1'b1;
          bubble_EXE   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if ((freeze_all || freeze_front) && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (bubble_EXE && (bubble_cnt_q != CntMax)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
    if (rst) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    wait_cnt_q    <= wait_cnt_d;
    mem_timeout_q <= mem_timeout_d;
    stall_cnt_q   <= stall_cnt_d;
    bubble_cnt_q  <= bubble_cnt_d;
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_hazard_detection_id.sv
// Scoreboard bench for hazard_detection_id: directed cycles push expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_detection_id;

  localparam int unsigned RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
  logic          src1_vld_ID, src2_vld_ID, WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM;
  logic          forward_en, branch_taken_EXE, mem_req_MEM, mem_ready;
  logic          freeze_front, bubble_EXE, freeze_all, flush_IF_ID, mem_timeout;
  logic [3:0]    stall_cnt, bubble_cnt;

  hazard_detection_id #(
    .REG_ADDR_W (RW),
    .MEM_TIMEOUT(8),
    .CNT_W      (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .src1_ID         (src1_ID),
    .src2_ID         (src2_ID),
    .src1_vld_ID     (src1_vld_ID),
    .src2_vld_ID     (src2_vld_ID),
    .dest_EXE        (dest_EXE),
    .WB_EN_EXE       (WB_EN_EXE),
    .MEM_R_EN_EXE    (MEM_R_EN_EXE),
    .dest_MEM        (dest_MEM),
    .WB_EN_MEM       (WB_EN_MEM),
    .forward_en      (forward_en),
    .branch_taken_EXE(branch_taken_EXE),
    .mem_req_MEM     (mem_req_MEM),
    .mem_ready       (mem_ready),
    .freeze_front    (freeze_front),
    .bubble_EXE      (bubble_EXE),
    .freeze_all      (freeze_all),
    .flush_IF_ID     (flush_IF_ID),
    .mem_timeout     (mem_timeout),
    .stall_cnt       (stall_cnt),
    .bubble_cnt      (bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    bit    ff, bub, fa, fl, to;
    int    sc, bc;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic clr();
    rst = 1'b0;
    src1_ID = '0; src2_ID = '0; dest_EXE = '0; dest_MEM = '0;
    src1_vld_ID = 1'b0; src2_vld_ID = 1'b0;
    WB_EN_EXE = 1'b0; MEM_R_EN_EXE = 1'b0; WB_EN_MEM = 1'b0;
    forward_en = 1'b1; branch_taken_EXE = 1'b0; mem_req_MEM = 1'b0; mem_ready = 1'b0;
  endtask

  // LDR r3 in EXE, ID reads r3 via src1.
  task automatic load_use3();
    WB_EN_EXE = 1'b1; MEM_R_EN_EXE = 1'b1; dest_EXE = 4'd3;
    src1_ID = 4'd3; src1_vld_ID = 1'b1;
  endtask

  task automatic cyc(input string nm, input bit ff, input bit bub, input bit fa, input bit fl,
                     input bit to, input int sc, input int bc);
    exp_t e;
    e.nm = nm; e.ff = ff; e.bub = bub; e.fa = fa; e.fl = fl; e.to = to; e.sc = sc; e.bc = bc;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (freeze_front !== e.ff || bubble_EXE !== e.bub || freeze_all !== e.fa ||
            flush_IF_ID !== e.fl || mem_timeout !== e.to ||
            stall_cnt !== 4'(e.sc) || bubble_cnt !== 4'(e.bc)) begin
          n_fail++;
          $display("FAIL %s: got ff=%b bub=%b fa=%b fl=%b to=%b sc=%0d bc=%0d, want ff=%b bub=%b fa=%b fl=%b to=%b sc=%0d bc=%0d",
                   e.nm, freeze_front, bubble_EXE, freeze_all, flush_IF_ID, mem_timeout,
                   stall_cnt, bubble_cnt, e.ff, e.bub, e.fa, e.fl, e.to, e.sc, e.bc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    clr();
    rst = 1'b1;
    @(posedge clk); #1;
    // Reset held with a branch and a load-use present: everything reads 0.
    clr(); rst = 1'b1; branch_taken_EXE = 1'b1; load_use3();
    cyc("reset",        0, 0, 0, 0, 0, 0, 0);

    clr(); load_use3();
    cyc("lu_stall",     1, 1, 0, 0, 0, 0, 0);
    clr(); WB_EN_MEM = 1'b1; dest_MEM = 4'd3; src1_ID = 4'd3; src1_vld_ID = 1'b1;
    cyc("lu_clear",     0, 0, 0, 0, 0, 1, 1);
    clr(); load_use3(); src2_ID = 4'd3; src1_vld_ID = 1'b0;
    cyc("lu_novld",     0, 0, 0, 0, 0, 1, 1);
    src2_vld_ID = 1'b1;
    cyc("lu_src2",      1, 1, 0, 0, 0, 1, 1);

    clr(); forward_en = 1'b0; WB_EN_EXE = 1'b1; dest_EXE = 4'd2;
    src1_ID = 4'd2; src1_vld_ID = 1'b1;
    cyc("nofwd_exe1",   1, 1, 0, 0, 0, 2, 2);
    clr(); forward_en = 1'b0; WB_EN_MEM = 1'b1; dest_MEM = 4'd2;
    src1_ID = 4'd2; src1_vld_ID = 1'b1;
    cyc("nofwd_exe2",   1, 1, 0, 0, 0, 3, 3);
    clr(); forward_en = 1'b0; src1_ID = 4'd2; src1_vld_ID = 1'b1;
    cyc("nofwd_done",   0, 0, 0, 0, 0, 4, 4);
    clr(); forward_en = 1'b0; WB_EN_MEM = 1'b1; dest_MEM = 4'd5;
    src2_ID = 4'd5; src2_vld_ID = 1'b1;
    cyc("nofwd_mem",    1, 1, 0, 0, 0, 4, 4);
    forward_en = 1'b1;
    cyc("fwd_mem",      0, 0, 0, 0, 0, 5, 5);

    clr(); branch_taken_EXE = 1'b1; load_use3();
    cyc("br_flush",     0, 1, 0, 1, 0, 5, 5);

    // Ready arrives 3 cycles late; branch and load-use held throughout.
    clr(); branch_taken_EXE = 1'b1; load_use3(); mem_req_MEM = 1'b1;
    cyc("mw_0",         0, 0, 1, 0, 0, 5, 6);
    cyc("mw_1",         0, 0, 1, 0, 0, 6, 6);
    cyc("mw_2",         0, 0, 1, 0, 0, 7, 6);
    mem_ready = 1'b1;
    cyc("mw_rel",       0, 1, 0, 1, 0, 8, 6);
    clr();
    cyc("mw_idle",      0, 0, 0, 0, 0, 8, 7);
    mem_req_MEM = 1'b1; mem_ready = 1'b1;
    cyc("mw_fast",      0, 0, 0, 0, 0, 8, 7);
    clr();
    cyc("mw_fast_idle", 0, 0, 0, 0, 0, 8, 7);

    // Timeout after 8 frozen cycles; stall_cnt saturates at 15 on the way.
    clr(); mem_req_MEM = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc("to_freeze",  0, 0, 1, 0, 0, (8 + i > 15) ? 15 : 8 + i, 7);
    end
    cyc("to_abort",     0, 0, 0, 0, 0, 15, 7);
    clr();
    cyc("to_sticky",    0, 0, 0, 0, 1, 15, 7);
    load_use3();
    cyc("to_sat",       1, 1, 0, 0, 1, 15, 7);
    clr();
    cyc("to_hold",      0, 0, 0, 0, 1, 15, 8);
    rst = 1'b1;
    @(posedge clk); #1;
    clr();
    cyc("to_cleared",   0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      clr(); load_use3();
      cyc("sat_stall",  1, 1, 0, 0, 0, (i > 15) ? 15 : i, (i > 15) ? 15 : i);
    end

    // Reset asserted while in MEM_WAIT with branch and stall present.
    clr(); mem_req_MEM = 1'b1;
    cyc("rw_0",         0, 0, 1, 0, 0, 15, 15);
    cyc("rw_1",         0, 0, 1, 0, 0, 15, 15);
    rst = 1'b1; branch_taken_EXE = 1'b1; load_use3();
    cyc("rw_rst",       0, 0, 0, 0, 0, 15, 15);
    clr();
    cyc("rw_after",     0, 0, 0, 0, 0, 0, 0);
    mem_req_MEM = 1'b1;
    cyc("rw_again",     0, 0, 1, 0, 0, 0, 0);
    mem_ready = 1'b1;
    cyc("rw_ready",     0, 0, 0, 0, 0, 1, 0);
    clr();

    repeat (2) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
